// File: rtl/entropy_collector_if.sv
// Register bus between the host and the entropy collector: 8-bit address,
// 16-bit write data, 16-bit combinational read data.
interface entropy_collector_if;
    logic        cs;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] dwrite;
    logic [15:0] dread;

    modport master (
        output cs,
        output we,
        output addr,
        output dwrite,
        input  dread
    );

    modport slave (
        input  cs,
        input  we,
        input  addr,
        input  dwrite,
        output dread
    );
endinterface

// File: rtl/entropy_collector.sv
// Entropy collector: synchronises the raw ring-oscillator vectors, samples
// and folds them to one bit, runs a repetition-count health test, debiases
// with a von Neumann extractor, packs 16-bit words and buffers them in a
// 4-entry FIFO readable over the register bus.
//
// Von Neumann extractor states:
//   state     | meaning
//   VN_FIRST  | waiting for the first bit of a pair
//   VN_SECOND | first bit stored, next sample completes the pair
module entropy_collector #(
    parameter logic [15:0] SAMPLE_DIV  = 16'd8,
    parameter logic [7:0]  REP_LIMIT   = 8'd32,
    parameter logic [7:0]  ADDR_CTRL   = 8'h20,
    parameter logic [7:0]  ADDR_STATUS = 8'h21,
    parameter logic [7:0]  ADDR_DATA   = 8'h22
) (
    input  logic                      clk,
    input  logic                      reset,
    entropy_collector_if.slave        bus,
    input  logic [15:0]               p_i,
    input  logic [15:0]               n_i,
    output logic                      word_valid_o,
    output logic                      health_fail_o
);

    typedef enum logic {
        VN_FIRST  = 1'b0,
        VN_SECOND = 1'b1
    } vn_state_t;

    // synchroniser
    logic [15:0] p_s1_q, p_s2_q, n_s1_q, n_s2_q;

    // control
    logic        enable_q, enable_d;
    logic        wr_ctrl;
    logic        clr_overflow;
    logic        clr_health;

    // sampling
    logic [15:0] div_q, div_d;
    logic        sample_stb;
    logic        sample_bit;

    // repetition test
    logic [7:0]  rep_ctr_q, rep_ctr_d;
    logic        prev_bit_q, prev_bit_d;
    logic        health_q, health_d;
    logic        rep_hit;

    // von Neumann extractor
    vn_state_t   vn_state_q, vn_state_d;
    logic        vn_bit_q, vn_bit_d;
    logic        emit_stb;
    logic        emit_bit;

    // packer
    logic [15:0] shreg_q, shreg_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        push_stb;

    // FIFO
    logic [15:0] fifo_mem_q [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        overflow_q, overflow_d;
    logic        word_valid_q;
    logic        push_ok;
    logic        pop_ok;
    logic        ovf_set;
    logic [15:0] fifo_head;

    // read-access edge detection for pops
    logic        data_rd_now;
    logic        rd_prev_q;
    logic        pop_req_q;

    // control decode and sample strobe
    always_comb begin
        wr_ctrl      = bus.cs && bus.we && (bus.addr == ADDR_CTRL);
        clr_overflow = wr_ctrl && bus.dwrite[1];
        clr_health   = wr_ctrl && bus.dwrite[2];
        enable_d     = wr_ctrl ? bus.dwrite[0] : enable_q;
        data_rd_now  = bus.cs && !bus.we && (bus.addr == ADDR_DATA);
        sample_stb   = enable_q && (div_q == SAMPLE_DIV - 16'd1);
        sample_bit   = ^(p_s2_q ^ n_s2_q);
        if (!enable_q || sample_stb) begin
            div_d = 16'd0;
        end else begin
            div_d = div_q + 16'd1;
        end
    end

    // repetition-count health test; a set of the flag beats a clear
    always_comb begin
        rep_ctr_d  = rep_ctr_q;
        prev_bit_d = prev_bit_q;
        health_d   = health_q;
        rep_hit    = 1'b0;
        if (!enable_q) begin
            rep_ctr_d = 8'd0;
        end else if (sample_stb) begin
            if ((rep_ctr_q == 8'd0) || (sample_bit != prev_bit_q)) begin
                rep_ctr_d = 8'd1;
            end else if (rep_ctr_q != 8'hFF) begin
                rep_ctr_d = rep_ctr_q + 8'd1;
            end
            prev_bit_d = sample_bit;
            rep_hit    = (rep_ctr_d == REP_LIMIT);
        end else if (clr_health) begin
            rep_ctr_d = 8'd0;
        end
        if (rep_hit) begin
            health_d = 1'b1;
        end else if (clr_health) begin
            health_d = 1'b0;
        end
    end

    // von Neumann state register
    always_ff @(posedge clk) begin
        if (reset) begin
            vn_state_q <= VN_FIRST;
            vn_bit_q   <= 1'b0;
        end else begin
            vn_state_q <= vn_state_d;
            vn_bit_q   <= vn_bit_d;
        end
    end

    // von Neumann next state: unequal pairs emit their first bit
    always_comb begin
        vn_state_d = vn_state_q;
        vn_bit_d   = vn_bit_q;
        emit_stb   = 1'b0;
        emit_bit   = vn_bit_q;
        if (!enable_q) begin
            vn_state_d = VN_FIRST;
            vn_bit_d   = 1'b0;
        end else if (sample_stb) begin
            unique case (vn_state_q)
                VN_FIRST: begin
                    vn_bit_d   = sample_bit;
                    vn_state_d = VN_SECOND;
                end
                VN_SECOND: begin
                    emit_stb   = (sample_bit != vn_bit_q);
                    vn_state_d = VN_FIRST;
                end
                default: vn_state_d = VN_FIRST;
            endcase
        end
    end

    // packer and FIFO bookkeeping; a full FIFO still accepts a push when
    // the same edge pops, so only a push with no room counts as overflow
    always_comb begin
        push_stb  = (bit_cnt_q == 5'd16);
        shreg_d   = emit_stb ? {shreg_q[14:0], emit_bit} : shreg_q;
        bit_cnt_d = (push_stb ? 5'd0 : bit_cnt_q) + {4'd0, emit_stb};

        pop_ok   = pop_req_q && (count_q != 3'd0);
        push_ok  = push_stb && ((count_q != 3'd4) || pop_ok);
        ovf_set  = push_stb && (count_q == 3'd4) && !pop_ok;
        wr_ptr_d = wr_ptr_q + {1'b0, push_ok};
        rd_ptr_d = rd_ptr_q + {1'b0, pop_ok};
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        fifo_head = fifo_mem_q[rd_ptr_q];
    end

    // main datapath and control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            p_s1_q       <= 16'd0;
            p_s2_q       <= 16'd0;
            n_s1_q       <= 16'd0;
            n_s2_q       <= 16'd0;
            enable_q     <= 1'b0;
            div_q        <= 16'd0;
            rep_ctr_q    <= 8'd0;
            prev_bit_q   <= 1'b0;
            health_q     <= 1'b0;
            shreg_q      <= 16'd0;
            bit_cnt_q    <= 5'd0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
            overflow_q   <= 1'b0;
            word_valid_q <= 1'b0;
            rd_prev_q    <= 1'b0;
            pop_req_q    <= 1'b0;
        end else begin
            p_s1_q       <= p_i;
            p_s2_q       <= p_s1_q;
            n_s1_q       <= n_i;
            n_s2_q       <= n_s1_q;
            enable_q     <= enable_d;
            div_q        <= div_d;
            rep_ctr_q    <= rep_ctr_d;
            prev_bit_q   <= prev_bit_d;
            health_q     <= health_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            word_valid_q <= (count_d != 3'd0);
            rd_prev_q    <= data_rd_now;
            pop_req_q    <= data_rd_now && !rd_prev_q;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q] <= shreg_q;
        end
    end

    // combinational register read
    always_comb begin
        bus.dread = 16'h0000;
        if (bus.cs && !bus.we) begin
            if (bus.addr == ADDR_CTRL) begin
                bus.dread = {15'd0, enable_q};
            end else if (bus.addr == ADDR_STATUS) begin
                bus.dread = {11'd0, health_q, overflow_q, count_q};
            end else if (bus.addr == ADDR_DATA) begin
                bus.dread = (count_q != 3'd0) ? fifo_head : 16'h0000;
            end
        end
    end

    assign word_valid_o  = word_valid_q;
    assign health_fail_o = health_q;

endmodule

// File: tb/tb_entropy_collector.sv
// Bench for entropy_collector: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a queue-based
// behavioural model.
module tb_entropy_collector;

    localparam logic [15:0] SAMPLE_DIV  = 16'd8;
    localparam logic [7:0]  REP_LIMIT   = 8'd32;
    localparam logic [7:0]  ADDR_CTRL   = 8'h20;
    localparam logic [7:0]  ADDR_STATUS = 8'h21;
    localparam logic [7:0]  ADDR_DATA   = 8'h22;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] p = 16'd0;
    logic [15:0] n = 16'd0;
    logic        word_valid;
    logic        health_fail;

    always #5 clk = ~clk;

    entropy_collector_if bus_if();

    entropy_collector #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .REP_LIMIT  (REP_LIMIT),
        .ADDR_CTRL  (ADDR_CTRL),
        .ADDR_STATUS(ADDR_STATUS),
        .ADDR_DATA  (ADDR_DATA)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_if),
        .p_i          (p),
        .n_i          (n),
        .word_valid_o (word_valid),
        .health_fail_o(health_fail)
    );

    int vectors = 0;
    int miscompares = 0;
    int edge_no = 0;
    int pat_mode = 0;
    int pat_e0 = 0;

    // behavioural model state
    bit          m_live = 0;
    bit          m_en, m_health, m_ov, m_last, m_pop_pend, m_last_acc;
    int          m_div, m_run;
    bit          m_hist[2];
    bit          m_pend[$];
    bit          m_bits[$];
    logic [15:0] m_q[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_dread();
        logic [15:0] r;
        r = 16'h0000;
        if (bus_if.cs && !bus_if.we) begin
            if (bus_if.addr == ADDR_CTRL) r = {15'd0, m_en};
            else if (bus_if.addr == ADDR_STATUS) r = {11'd0, m_health, m_ov, 3'(m_q.size())};
            else if (bus_if.addr == ADDR_DATA) r = (m_q.size() != 0) ? m_q[0] : 16'h0000;
        end
        return r;
    endfunction

    // one clock edge of the model, using the inputs present before the edge
    task automatic model_step();
        bit          b, samp, wr, acc, push, pop, hit, ovs;
        logic [15:0] w;
        if (reset) begin
            m_en = 0; m_health = 0; m_ov = 0; m_last = 0;
            m_pop_pend = 0; m_last_acc = 0;
            m_div = 0; m_run = 0;
            m_hist[0] = 0; m_hist[1] = 0;
            m_pend.delete(); m_bits.delete(); m_q.delete();
            m_live = 1;
            return;
        end
        wr   = bus_if.cs && bus_if.we && (bus_if.addr == ADDR_CTRL);
        b    = m_hist[0];
        m_hist[0] = m_hist[1];
        m_hist[1] = ^(p ^ n);
        samp = m_en && (m_div == int'(SAMPLE_DIV) - 1);
        if (!m_en || samp) m_div = 0; else m_div++;

        hit = 0;
        if (!m_en) m_run = 0;
        else if (samp) begin
            if (m_run == 0 || b != m_last) m_run = 1;
            else if (m_run < 255) m_run++;
            m_last = b;
            hit = (m_run == int'(REP_LIMIT));
        end else if (wr && bus_if.dwrite[2]) m_run = 0;
        if (hit) m_health = 1;
        else if (wr && bus_if.dwrite[2]) m_health = 0;

        push = (m_bits.size() == 16);
        w = 16'h0000;
        if (push) begin
            for (int i = 0; i < 16; i++) if (m_bits[i]) w[15-i] = 1'b1;
            m_bits.delete();
        end
        if (!m_en) m_pend.delete();
        else if (samp) begin
            if (m_pend.size() == 0) m_pend.push_back(b);
            else begin
                if (m_pend[0] != b) m_bits.push_back(m_pend[0]);
                m_pend.delete();
            end
        end

        pop = m_pop_pend && (m_q.size() > 0);
        acc = bus_if.cs && !bus_if.we && (bus_if.addr == ADDR_DATA);
        m_pop_pend = acc && !m_last_acc;
        m_last_acc = acc;
        ovs = 0;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < 4) m_q.push_back(w);
            else ovs = 1;
        end
        if (ovs) m_ov = 1;
        else if (wr && bus_if.dwrite[1]) m_ov = 0;
        if (wr) m_en = bus_if.dwrite[0];
    endtask

    // compare process: outputs against the model every cycle, mid-period
    always @(negedge clk) begin
        if (m_live) begin
            chk("word_valid", 16'(word_valid), 16'(m_q.size() != 0));
            chk("health_fail", 16'(health_fail), 16'(m_health));
            chk("dread", bus_if.dread, model_dread());
        end
    end

    function automatic logic pat_bit(input int k);
        int j;
        j = (k >= 6) ? (k - 6) / 8 : 0;
        if (pat_mode == 1) return (j % 2 == 0);
        return ((j % 4 == 1) || (j % 4 == 2));
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        edge_no++;
        #1;
        if (pat_mode != 0) begin
            p = {15'd0, pat_bit(edge_no + 1 - pat_e0)};
            n = 16'd0;
        end
    endtask

    task automatic wr_ctrl(input logic [15:0] v);
        bus_if.cs = 1; bus_if.we = 1; bus_if.addr = ADDR_CTRL; bus_if.dwrite = v;
        tick();
        bus_if.cs = 0; bus_if.we = 0;
    endtask

    task automatic rd_lit(input logic [7:0] a, input logic [15:0] exp, input string name);
        bus_if.cs = 1; bus_if.we = 0; bus_if.addr = a;
        #1;
        chk(name, bus_if.dread, exp);
        tick();
        bus_if.cs = 0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic start_pattern(input int mode);
        pat_mode = mode;
        pat_e0 = edge_no + 1;
        wr_ctrl(16'h0001);
    endtask

    task automatic wait_fifo(input int k, input string name);
        int g;
        g = 0;
        while (m_q.size() < k && g < 3000) begin
            tick();
            g++;
        end
        if (g >= 3000) chk(name, 16'(m_q.size()), 16'(k));
    endtask

    initial begin
        int pmode;
        int r;
        bus_if.cs = 0; bus_if.we = 0; bus_if.addr = 8'h00; bus_if.dwrite = 16'h0000;
        pmode = 0;

        // reset state
        do_reset();
        rd_lit(ADDR_STATUS, 16'h0000, "reset_status");
        rd_lit(ADDR_CTRL, 16'h0000, "reset_ctrl");
        rd_lit(ADDR_DATA, 16'h0000, "reset_data");
        chk("reset_word_valid", 16'(word_valid), 16'h0000);
        chk("reset_health", 16'(health_fail), 16'h0000);

        // constant input: every pair is 11, health trips on the 32nd sample
        p = 16'h0001; n = 16'h0000;
        do_reset();
        wr_ctrl(16'h0001);
        repeat (255) tick();
        chk("health_before_32", 16'(health_fail), 16'h0000);
        tick();
        chk("health_at_32", 16'(health_fail), 16'h0001);
        wr_ctrl(16'h0005);
        chk("health_cleared", 16'(health_fail), 16'h0000);
        rd_lit(ADDR_CTRL, 16'h0001, "enable_kept");
        chk("const_no_word", 16'(word_valid), 16'h0000);

        // alternating 1,0: every pair emits 1
        do_reset();
        start_pattern(1);
        repeat (256) tick();
        chk("alt_wv_before_push", 16'(word_valid), 16'h0000);
        tick();
        chk("alt_wv_after_push", 16'(word_valid), 16'h0001);
        rd_lit(ADDR_STATUS, 16'h0001, "alt_status_1");
        rd_lit(ADDR_DATA, 16'hFFFF, "alt_word");
        rd_lit(ADDR_STATUS, 16'h0000, "alt_status_0");

        // five words with no reads: overflow
        pat_mode = 0;
        do_reset();
        start_pattern(1);
        repeat (1290) tick();
        rd_lit(ADDR_STATUS, 16'h000C, "ovf_status");
        for (int i = 0; i < 4; i++) rd_lit(ADDR_DATA, 16'hFFFF, "ovf_word");
        wr_ctrl(16'h0003);
        rd_lit(ADDR_STATUS, 16'h0000, "ovf_cleared");

        // held chip select pops once; reset drops buffered words
        pat_mode = 0;
        do_reset();
        start_pattern(1);
        wait_fifo(2, "wait_two_words");
        wr_ctrl(16'h0000);
        bus_if.cs = 1; bus_if.we = 0; bus_if.addr = ADDR_DATA;
        repeat (3) tick();
        bus_if.cs = 0;
        tick();
        rd_lit(ADDR_STATUS, 16'h0001, "held_cs_one_pop");
        start_pattern(1);
        wait_fifo(3, "wait_three_words");
        rd_lit(ADDR_STATUS, 16'h0003, "three_buffered");
        do_reset();
        chk("reset_mid_wv", 16'(word_valid), 16'h0000);
        rd_lit(ADDR_STATUS, 16'h0000, "reset_mid_status");
        rd_lit(ADDR_CTRL, 16'h0000, "reset_mid_ctrl");

        // pairs 01,10 alternating: emitted bits 0,1,0,1...
        pat_mode = 0;
        do_reset();
        start_pattern(2);
        wait_fifo(1, "wait_5555");
        rd_lit(ADDR_DATA, 16'h5555, "word_5555");

        // randomized traffic
        pat_mode = 0;
        do_reset();
        wr_ctrl(16'h0001);
        for (int c = 0; c < 20000; c++) begin
            if (c % 400 == 0) pmode = $urandom_range(0, 2);
            case (pmode)
                0: begin p = 16'($urandom); n = 16'($urandom); end
                1: ;
                default: if ($urandom_range(0, 5) == 0) p = 16'($urandom);
            endcase
            r = $urandom_range(0, 999);
            reset = (r == 0);
            if (r < 6) begin
                bus_if.cs = 1; bus_if.we = 1; bus_if.addr = ADDR_CTRL;
                bus_if.dwrite = 16'($urandom);
                bus_if.dwrite[0] = ($urandom_range(0, 9) != 0);
            end else if (r < 10) begin
                bus_if.cs = 1; bus_if.we = 1; bus_if.addr = 8'($urandom);
                bus_if.dwrite = 16'($urandom);
            end else if ($urandom_range(0, 1) == 0 || bus_if.we) begin
                bus_if.cs = ($urandom_range(0, 2) == 0);
                bus_if.we = 0;
                case ($urandom_range(0, 3))
                    0: bus_if.addr = ADDR_CTRL;
                    1: bus_if.addr = ADDR_STATUS;
                    2: bus_if.addr = ADDR_DATA;
                    default: bus_if.addr = 8'($urandom);
                endcase
            end
            tick();
        end
        reset = 0;
        bus_if.cs = 0; bus_if.we = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/entropy_collector.md
Name: entropy_collector

Overview:
- Sits directly downstream of the ring-oscillator entropy generator and consumes its raw 16-bit p and n oscillator vectors.
- Synchronises and samples them at a programmable rate, then folds each sample to one bit.
- Debiases the bit stream with a von Neumann extractor, runs a repetition-count health test, and packs the output into 16-bit words.
- Words are buffered in a 4-entry FIFO that the host reads over the same 8-bit-address / 16-bit-data register bus used by the rest of the core.

Parameters:
- SAMPLE_DIV, 16'd8: clk cycles per sample (legal 2..65535).
- REP_LIMIT, 8'd32: consecutive identical folded bits that trip the health flag.
- ADDR_CTRL, 8'h20: control register (R/W).
- ADDR_STATUS, 8'h21: status register (RO).
- ADDR_DATA, 8'h22: FIFO head (RO; a read pops).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cs  in  1  register chip select
- we  in  1  write enable (1 = write, 0 = read)
- addr  in  8  register address
- dwrite  in  16  write data
- dread  out  16  read data, combinational
- p  in  16  raw oscillator outputs, asynchronous to clk
- n  in  16  raw oscillator outputs, asynchronous to clk
- word_valid  out  1  FIFO non-empty (registered)
- health_fail  out  1  sticky repetition-test failure (registered)

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset state:
  - sync flops, divider, pair state, shift register, bit counter, rep counter, FIFO pointers and count all 0.
  - ctrl.enable=0; overflow=0; health_fail=0; word_valid=0.
- Synchroniser: p and n each pass through 2 flop stages.
- Sampling:
  - Divider counts 0..SAMPLE_DIV-1 only while enable=1, and holds at 0 while enable=0.
  - When the divider is at SAMPLE_DIV-1, take a sample: bit = XOR-reduce(p_sync ^ n_sync).
- Repetition test, on each sample:
  - If bit equals the previous sample bit, increment rep_ctr (saturating at 255); otherwise reset rep_ctr to 1.
  - When rep_ctr reaches REP_LIMIT, set health_fail. It stays set until a clear.
  - The first sample after enable rises sets rep_ctr=1.
- Von Neumann extractor: two-state FSM.
  - FIRST: store bit, go to SECOND.
  - SECOND: pair 01 emits 0, pair 10 emits 1, pairs 00 and 11 emit nothing; always return to FIRST.
  - Dropping enable returns the FSM to FIRST and discards any stored bit.
- Packer:
  - Each emitted bit is shifted in at the LSB: shreg <= {shreg[14:0], bit}. The first emitted bit ends at bit 15.
  - After 16 emitted bits, push the word the cycle after the 16th bit and clear the count. The partial word is preserved across enable toggles.
- FIFO: 4 entries, count 0..4.
  - Push when full: word dropped, overflow set (sticky), FIFO unchanged.
  - Pop happens one cycle after a new read access to ADDR_DATA. A new access is cs&~we&addr==ADDR_DATA in a cycle where the previous cycle did not have the same condition. Holding cs for several cycles pops once.
  - Pop when empty: no effect; dread returns 0.
  - Simultaneous push and pop with count 4: both occur, count stays 4, no overflow.
  - Simultaneous push and pop with count 0: push only.
- Writes (cs&we):
  - ADDR_CTRL: enable=dwrite[0].
  - dwrite[1]=1 clears overflow. dwrite[2]=1 clears health_fail and resets rep_ctr to 0. Both clear bits are self-clearing.
  - If a clear and a set of the same flag happen in the same cycle, set wins.
  - Writes to any other address are ignored.
- Reads (cs&~we), dread is combinational; every other case returns 16'h0000:
  - ADDR_CTRL returns {15'b0, enable}.
  - ADDR_STATUS returns {11'b0, health_fail, overflow, count[2:0]}.
  - ADDR_DATA returns the FIFO head (the value before the pop).
- word_valid = (count != 0), registered form of the count.
- Reset mid-operation: everything returns to reset state within the same edge; buffered words are lost.

Test Plan:
- Reset, then read ADDR_STATUS, ADDR_CTRL and ADDR_DATA -> all return 16'h0000; word_valid=0, health_fail=0.
- enable=1, SAMPLE_DIV=8; drive p=16'h0001, n=0 held constant -> no word ever pushed (all pairs 11); health_fail=1 at the 32nd sample; writing ctrl=16'h0005 clears it with enable kept on.
- enable=1; toggle p[0] so successive samples are 1,0,1,0..., n=0 -> every pair emits 1; after 32 samples word_valid=1 and a read of ADDR_DATA returns 16'hFFFF; STATUS count goes from 1 to 0 after the read.
- Same stimulus as above, no reads, for 5 words' worth of samples -> STATUS=16'h000C (overflow=1, count=4); the four reads return 16'hFFFF; writing ctrl=16'h0003 clears overflow.
- Hold cs with addr=ADDR_DATA for 3 cycles with count=2 -> exactly one pop, count=1; assert reset with 3 words buffered -> count=0, enable=0 on the next cycle.
- Alternate per-sample pairs 0,1 then 1,0 -> emitted bits 0,1,0,1...; the first word read is 16'h5555.
